// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arb_pkg
//  Description : Shared constants, the in-flight tag type and a small helper
//                for the ROM read arbiter.
//                The ID width is sized for the largest legal requester count
//                (8) so one tag type serves every build of the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package rom_arb_pkg;

    localparam int c_NUM_REQ_MAX = 8;
    localparam int c_ID_W        = $clog2(c_NUM_REQ_MAX);

    // One entry of the response-routing pipe: which requester owns the read
    // currently travelling through the ROM, if any.
    typedef struct packed {
        logic              vld;
        logic [c_ID_W-1:0] id;
    } rom_tag_t;

    // Round-robin successor of a granted index, wrapping at num_req-1.
    function automatic logic [c_ID_W-1:0] rr_next(input logic [c_ID_W-1:0] idx,
                                                  input int                num_req);
        logic [c_ID_W-1:0] v_last;
        v_last = c_ID_W'(num_req - 1);
        if (idx == v_last) begin
            return '0;
        end
        return idx + c_ID_W'(1);
    endfunction

endpackage : rom_arb_pkg
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant
//  Description : Combinational round-robin search. Starting at i_ptr and
//                wrapping modulo NUM_REQ, the first asserted request wins.
//  Ports       : i_req_valid  request vector
//                i_ptr        index with highest priority this cycle
//                o_grant      one-hot grant (all zero when nothing requests)
//                o_grant_idx  binary index of the winner
//                o_grant_vld  a winner exists
//  Revision    : 1.0  initial release
// ============================================================================
module rr_grant
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [c_ID_W-1:0]  i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [c_ID_W-1:0]  o_grant_idx,
    output logic               o_grant_vld
);

    // Two passes instead of a rotate: the first looks only at indices at or
    // above the pointer; if nobody there is asking, the second pass picks the
    // lowest asserted index, which is exactly the wrapped continuation.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_grant_vld && i_req_valid[i] && (c_ID_W'(i) >= i_ptr)) begin
                o_grant[i]  = 1'b1;
                o_grant_idx = c_ID_W'(i);
                o_grant_vld = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_grant_vld && i_req_valid[i]) begin
                o_grant[i]  = 1'b1;
                o_grant_idx = c_ID_W'(i);
                o_grant_vld = 1'b1;
            end
        end
    end

endmodule : rr_grant
`default_nettype wire

// File: rtl/rom_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rom_read_arbiter
//  Description : Shares one synchronous ROM between NUM_REQ requesters with
//                round-robin arbitration, one grant per clock. Each read is
//                tagged with its requester ID and the data is routed back as
//                a one-hot rsp_valid pulse, in issue order.
//  Ports       : clk, rst         clock, asynchronous active-high reset
//                i_req_valid      per-requester read request
//                i_req_addr       packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//                o_req_ready      one-hot grant (accept = valid && ready)
//                o_rsp_valid      one-hot, single-cycle response pulse
//                o_rsp_data       response data, qualified by o_rsp_valid
//                o_rom_address    registered address to the ROM
//                i_rom_data       ROM read data, ROM_LATENCY edges after address
//  Revision    : 1.0  initial release
// ============================================================================
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int ROM_LATENCY = 1
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic [ADDR_W-1:0]         o_rom_address,
    input  logic [DATA_W-1:0]         i_rom_data
);

    // One stage to register the address, then ROM_LATENCY stages while the
    // ROM produces data; the last stage lines up with valid i_rom_data.
    localparam int c_PIPE_D = ROM_LATENCY + 1;

    logic [c_ID_W-1:0]  r_ptr;
    logic [ADDR_W-1:0]  r_rom_address;
    rom_tag_t           r_pipe [c_PIPE_D];
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;

    logic [NUM_REQ-1:0] w_grant;
    logic [c_ID_W-1:0]  w_grant_idx;
    logic               w_grant_vld;
    logic [ADDR_W-1:0]  w_sel_addr;
    rom_tag_t           w_push_tag;
    rom_tag_t           w_rsp_tag;
    logic [NUM_REQ-1:0] w_rsp_onehot;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_grant #(
        .NUM_REQ     (NUM_REQ)
    ) u_rr_grant (
        .i_req_valid (i_req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

    // Ready is masked while reset is held so no requester believes it was
    // accepted by an edge the reset is overriding.
    assign o_req_ready = rst ? '0 : w_grant;

    // The grant is one-hot, so an AND-OR mux selects the winner's address.
    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_sel_addr | i_req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        w_push_tag     = '0;
        w_push_tag.vld = w_grant_vld;
        w_push_tag.id  = w_grant_idx;
    end

    // ------------------------------------------------------------------
    // Pointer and ROM address register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr         <= '0;
            r_rom_address <= '0;
        end else if (w_grant_vld) begin
            r_ptr         <= rr_next(w_grant_idx, NUM_REQ);
            r_rom_address <= w_sel_addr;
        end
    end

    assign o_rom_address = r_rom_address;

    // ------------------------------------------------------------------
    // Tag pipe: a bubble tag is pushed on idle cycles so every entry stays
    // aligned with the ROM data it describes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < c_PIPE_D; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= w_push_tag;
            for (int k = 1; k < c_PIPE_D; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign w_rsp_tag = r_pipe[c_PIPE_D-1];

    always_comb begin
        w_rsp_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rsp_onehot[i] = w_rsp_tag.vld && (w_rsp_tag.id == c_ID_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Response register: data holds between responses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_rsp_onehot;
            if (w_rsp_tag.vld) begin
                r_rsp_data <= i_rom_data;
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;

`ifndef SYNTHESIS
    a_ready_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(o_req_ready));
    a_rsp_onehot   : assert property (@(posedge clk) disable iff (rst)
        $onehot0(o_rsp_valid));
    a_ready_valid  : assert property (@(posedge clk) disable iff (rst)
        ((o_req_ready & ~i_req_valid) == '0));
`endif

endmodule : rom_read_arbiter
`default_nettype wire

// File: tb/tb_rom_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_read_arbiter
//  Description : Self-checking bench for rom_read_arbiter with a golden ROM
//                model, a round-robin reference and an expected-response
//                queue carrying due cycle, requester ID and address.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rom_read_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int ROM_LATENCY = 1;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr  = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [ADDR_W-1:0]         rom_address;
    logic [DATA_W-1:0]         rom_data;

    always #5 clk = ~clk;

    rom_read_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .ROM_LATENCY   (ROM_LATENCY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (req_valid),
        .i_req_addr    (req_addr),
        .o_req_ready   (req_ready),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_data    (rsp_data),
        .o_rom_address (rom_address),
        .i_rom_data    (rom_data)
    );

    // Golden ROM: contents are a fixed scramble of the address, read data
    // appears ROM_LATENCY edges after the address.
    function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        return DATA_W'((a * 37) ^ 8'h5A);
    endfunction

    logic [DATA_W-1:0] rom_pipe [ROM_LATENCY];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_f(rom_address);
        for (int k = 1; k < ROM_LATENCY; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_data = rom_pipe[ROM_LATENCY-1];

    // ------------------------------------------------------------------
    // Reference state
    // ------------------------------------------------------------------
    typedef struct {
        int                id;
        logic [ADDR_W-1:0] addr;
        int                due;
    } exp_t;

    exp_t              exp_q[$];
    int                m_ptr;
    logic [ADDR_W-1:0] m_addr;
    int                cyc;
    int                acc_cnt [NUM_REQ];
    int                rsp_cnt [NUM_REQ];
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check the combinational grant and registered outputs at the
    // negedge, then advance the reference model across the posedge.
    task automatic step();
        int                g;
        logic [31:0]       exp_ready;
        logic [ADDR_W-1:0] sel;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
        end
        exp_ready = (g >= 0) ? (32'd1 << g) : 32'd0;
        chk_eq("req_ready", 32'(req_ready), exp_ready);
        chk_eq("rom_address", 32'(rom_address), 32'(m_addr));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk_eq("rsp_valid", 32'(rsp_valid), 32'd1 << exp_q[0].id);
            chk_eq("rsp_data", 32'(rsp_data), 32'(rom_f(exp_q[0].addr)));
            rsp_cnt[exp_q[0].id]++;
            void'(exp_q.pop_front());
        end else begin
            chk_eq("rsp_idle", 32'(rsp_valid), 32'd0);
        end
        sel = (g >= 0) ? req_addr[g*ADDR_W +: ADDR_W] : '0;
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            exp_q.push_back('{id: g, addr: sel, due: cyc + ROM_LATENCY + 1});
            m_addr = sel;
            m_ptr  = (g + 1) % NUM_REQ;
            acc_cnt[g]++;
        end
        #1;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic apply_reset();
        @(negedge clk);
        req_valid = '1;
        rst = 1'b1;
        #1;
        chk_eq("rst_rom_address", 32'(rom_address), 32'd0);
        chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk_eq("rst_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        m_ptr  = 0;
        m_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            acc_cnt[i] = 0;
            rsp_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        cyc += 2;
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        repeat (ROM_LATENCY + 3) begin
            req_addr = {$urandom, $urandom};
            step();
        end
        chk_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_addrs(input logic [ADDR_W-1:0] base);
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = base + ADDR_W'(i);
    endtask

    initial begin
        int sweep;
        cyc = 0;
        apply_reset();

        // All requesters valid: strict rotation 0,1,2,3,0
        req_valid = '1;
        set_addrs(8'h10);
        repeat (5) step();
        drain();

        // Single requester held for three cycles
        req_valid = 4'b0001;
        req_addr  = '0;
        req_addr[0 +: ADDR_W] = 8'h05;
        repeat (3) step();
        drain();

        // Rotation skip: grant 1, then 3, then wrap to 0
        req_valid = '1;
        set_addrs(8'h40);
        while (m_ptr != 1) step();
        step();
        req_valid = 4'b1001;
        repeat (2) step();
        chk_eq("ptr_after_skip", 32'(m_ptr), 32'd1);
        drain();

        // Reset with two reads in flight, then silence until new grants
        req_valid = '1;
        set_addrs(8'h80);
        repeat (2) step();
        apply_reset();
        repeat (ROM_LATENCY + 3) step();

        // Random traffic with an address sweep
        sweep = 0;
        for (int n = 0; n < 1000; n++) begin
            req_valid = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++)
                req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(sweep + i * 64);
            sweep++;
            step();
        end
        drain();
        for (int i = 0; i < NUM_REQ; i++) chk_eq("rsp_count", 32'(rsp_cnt[i]), 32'(acc_cnt[i]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rom_read_arbiter
`default_nettype wire
